// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter/sequencer sharing one Alu between NUM_REQ requesters.
// Optional illegal-opcode trap (opcodes 3'b1xx) is enabled by defining ALU_ARB_OPCHECK_EN.
module alu_arbiter #(
  parameter int unsigned DATA_WIDTH  = 512,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [3*NUM_REQ-1:0]           req_opcode,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_a,
  input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [DATA_WIDTH-1:0]          resp_data,
  output logic                           resp_error,
  output logic [2:0]                     alu_opcode,
  output logic [DATA_WIDTH-1:0]          alu_a,
  output logic [DATA_WIDTH-1:0]          alu_b,
  input  logic [DATA_WIDTH-1:0]          alu_out
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                 state_q;
  logic [PTR_W-1:0]       rr_ptr_q;
  logic [PTR_W-1:0]       rr_ptr_d;
  logic [PTR_W-1:0]       grant_q;
  logic [CNT_W-1:0]       wait_cnt_q;
  logic [PTR_W-1:0]       win_idx;
  logic                   win_found;
  logic                   illegal_op;

  logic [2:0]             op_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]  a_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]  b_arr  [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_arr[i] = req_opcode[3*i +: 3];
    assign a_arr[i]  = req_a[DATA_WIDTH*i +: DATA_WIDTH];
    assign b_arr[i]  = req_b[DATA_WIDTH*i +: DATA_WIDTH];
  end

  // Round-robin search: first valid requester at or after rr_ptr_q, wrapping.
  always_comb begin
    int unsigned      idx;
    logic [PTR_W-1:0] idx_w;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = PTR_W'(idx);
      if (!win_found && req_valid[idx_w]) begin
        win_found = 1'b1;
        win_idx   = idx_w;
      end
    end
  end

  assign rr_ptr_d = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && !rst && win_found) req_ready[win_idx] = 1'b1;
  end

`ifdef ALU_ARB_OPCHECK_EN
  assign illegal_op = op_arr[win_idx][2];
`else
  assign illegal_op = 1'b0;
`endif

  // Sequencer: accept -> wait out ALU latency -> one-cycle response pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      wait_cnt_q <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      resp_data  <= '0;
      resp_valid <= '0;
      resp_error <= 1'b0;
    end else begin
      resp_valid <= '0;
      resp_error <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            grant_q  <= win_idx;
            rr_ptr_q <= rr_ptr_d;
            if (illegal_op) begin
              resp_data  <= '0;
              resp_error <= 1'b1;
              resp_valid <= NUM_REQ'(1) << win_idx;
              state_q    <= S_RESP;
            end else begin
              alu_opcode <= op_arr[win_idx];
              alu_a      <= a_arr[win_idx];
              alu_b      <= b_arr[win_idx];
              wait_cnt_q <= CNT_W'(ALU_LATENCY);
              state_q    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt_q == '0) begin
            resp_data  <= alu_out;
            resp_valid <= NUM_REQ'(1) << grant_q;
            state_q    <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q - CNT_W'(1);
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle corner
// sequences and randomized traffic against a cycle-scheduled scoreboard model.
module tb_alu_arbiter;

  localparam int DW  = 512;
  localparam int NR  = 4;
  localparam int LAT = 1;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [3*NR-1:0] req_opcode;
  logic [DW*NR-1:0] req_a;
  logic [DW*NR-1:0] req_b;
  logic [NR-1:0]   resp_valid;
  logic [DW-1:0]   resp_data;
  logic            resp_error;
  logic [2:0]      alu_opcode;
  logic [DW-1:0]   alu_a;
  logic [DW-1:0]   alu_b;
  logic [DW-1:0]   alu_out;

  logic [2:0]      t_op [NR];
  logic [DW-1:0]   t_a  [NR];
  logic [DW-1:0]   t_b  [NR];

  alu_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ALU_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_opcode[3*i +: 3] = t_op[i];
      req_a[DW*i +: DW]    = t_a[i];
      req_b[DW*i +: DW]    = t_b[i];
    end
  end

  // Single-stage Alu stand-in: PARITY=0, POPCOUNT=1, ROTR=2, ROTL=3.
  int alu_sh;
  assign alu_sh = int'(alu_b % DW);
  always_ff @(posedge clk) begin
    case (alu_opcode)
      3'd0:    alu_out <= DW'(^alu_a);
      3'd1:    alu_out <= DW'($countones(alu_a));
      3'd2:    alu_out <= (alu_a >> alu_sh) | (alu_a << (DW - alu_sh));
      3'd3:    alu_out <= (alu_a << alu_sh) | (alu_a >> (DW - alu_sh));
      default: alu_out <= '0;
    endcase
  end

  // Bit-level reference for what a requester should get back.
  function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW-1:0] r;
    int n, s;
    r = '0;
    n = 0;
    s = int'(b % DW);
    for (int i = 0; i < DW; i++) if (a[i]) n++;
    case (op)
      3'd0: r = DW'(n % 2);
      3'd1: r = DW'(n);
      3'd2: for (int i = 0; i < DW; i++) r[i] = a[(i + s) % DW];
      3'd3: for (int i = 0; i < DW; i++) r[(i + s) % DW] = a[i];
      default: r = '0;
    endcase
    return r;
  endfunction

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            due;
    int            grant;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  int            grant_log[$];
  int            cyc = 0;
  int            busy_until = 0;
  int            ptr = 0;
  logic          accepted;
  logic          resp_seen;
  logic [DW-1:0] last_resp;
  logic [2:0]    m_op;
  logic [DW-1:0] m_a, m_b;

  // One clock of the model: check outputs now, schedule any acceptance, advance.
  task automatic step();
    logic [NR-1:0] exp_rdy, exp_rv;
    logic [1:0]    gi;
    logic [2:0]    op;
    exp_t          e;
    int            g, idx;
    #1;
    accepted  = 1'b0;
    resp_seen = 1'b0;
    exp_rv    = '0;
    if (sb.size() > 0 && sb[0].due == cyc) exp_rv = NR'(1) << sb[0].grant;
    chk("resp_valid", DW'(resp_valid), DW'(exp_rv));
    if (exp_rv != '0) begin
      chk("resp_data", resp_data, sb[0].data);
      chk("resp_error", DW'(resp_error), DW'(sb[0].err));
      chk("alu_opcode_hold", DW'(alu_opcode), DW'(m_op));
      chk("alu_a_hold", alu_a, m_a);
      chk("alu_b_hold", alu_b, m_b);
      last_resp = resp_data;
      resp_seen = 1'b1;
      void'(sb.pop_front());
    end
    g = -1;
    if (!rst && cyc >= busy_until) begin
      for (int k = 0; k < NR; k++) begin
        idx = (ptr + k) % NR;
        if (g < 0 && req_valid[2'(idx)]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? (NR'(1) << g) : '0;
    chk("req_ready", DW'(req_ready), DW'(exp_rdy));
    if (rst) begin
      sb.delete();
      ptr = 0;
      busy_until = 0;
      m_op = '0;
      m_a = '0;
      m_b = '0;
    end else if (g >= 0) begin
      gi = 2'(g);
      op = t_op[gi];
      accepted = 1'b1;
      grant_log.push_back(g);
      ptr = (g + 1) % NR;
      e.grant = g;
`ifdef ALU_ARB_OPCHECK_EN
      if (op[2]) begin
        e.due = cyc + 1; e.data = '0; e.err = 1'b1;
        busy_until = cyc + 2;
      end else
`endif
      begin
        e.due = cyc + LAT + 2; e.data = ref_alu(op, t_a[gi], t_b[gi]); e.err = 1'b0;
        busy_until = cyc + LAT + 3;
        m_op = op; m_a = t_a[gi]; m_b = t_b[gi];
      end
      sb.push_back(e);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_accept(input string name);
    for (int n = 0; n < 40 && !accepted; n++) step();
    chk(name, DW'(accepted), DW'(1));
  endtask

  task automatic wait_resp(input string name);
    resp_seen = 1'b0;
    for (int n = 0; n < 40 && !resp_seen; n++) step();
    chk(name, DW'(resp_seen), DW'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() > 0 || cyc < busy_until) && n < 50) begin
      step();
      n++;
    end
    chk("drain", DW'(sb.size()), DW'(0));
  endtask

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] r;
    for (int w = 0; w < DW / 32; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  typedef struct {
    int            req;
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[6];
  int   cnt[NR];

  initial begin
    vecs[0] = '{req: 1, op: 3'd0, a: DW'(8'hAC), b: '0,       exp: DW'(0)};
    vecs[1] = '{req: 1, op: 3'd0, a: DW'(8'hAD), b: '0,       exp: DW'(1)};
    vecs[2] = '{req: 2, op: 3'd1, a: DW'(8'hAD), b: '0,       exp: DW'(5)};
    vecs[3] = '{req: 2, op: 3'd1, a: DW'(8'hED), b: '0,       exp: DW'(6)};
    vecs[4] = '{req: 0, op: 3'd2, a: DW'(8'hAD), b: DW'(3),
                exp: {3'b101, 504'b0, 5'b10101}};
    vecs[5] = '{req: 3, op: 3'd3, a: {8'hAD, 504'b0}, b: DW'(3),
                exp: {5'b01101, 504'b0, 3'b101}};

    for (int i = 0; i < NR; i++) begin
      t_op[i] = '0; t_a[i] = '0; t_b[i] = '0;
    end
    m_op = '0; m_a = '0; m_b = '0;
    last_resp = '0; accepted = 1'b0; resp_seen = 1'b0;

    // Reset with every requester asking.
    rst = 1'b1;
    req_valid = '1;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    chk("rst_resp_valid", DW'(resp_valid), '0);
    chk("rst_resp_data", resp_data, '0);
    chk("rst_resp_error", DW'(resp_error), '0);
    chk("rst_alu_opcode", DW'(alu_opcode), '0);
    chk("rst_alu_a", alu_a, '0);
    chk("rst_alu_b", alu_b, '0);
    grant_log.delete();
    wait_accept("rst_accept");
    req_valid = '0;
    chk("rst_first_grant", DW'(grant_log[0]), DW'(0));
    drain();

    // Directed vector table, one requester at a time.
    for (int v = 0; v < 6; v++) begin
      t_op[2'(vecs[v].req)] = vecs[v].op;
      t_a[2'(vecs[v].req)]  = vecs[v].a;
      t_b[2'(vecs[v].req)]  = vecs[v].b;
      req_valid = NR'(1) << vecs[v].req;
      accepted = 1'b0;
      wait_accept("vec_accept");
      req_valid = '0;
      wait_resp("vec_resp");
      chk($sformatf("vec%0d_data", v), last_resp, vecs[v].exp);
      drain();
    end

    // Fairness: everyone valid for 16 operations, pointer starts at 0.
    for (int i = 0; i < NR; i++) begin
      t_op[i] = 3'($urandom_range(0, 3)); t_a[i] = rand_wide(); t_b[i] = rand_wide();
      cnt[i] = 0;
    end
    grant_log.delete();
    req_valid = '1;
    for (int n = 0; n < 100 && grant_log.size() < 16; n++) step();
    req_valid = '0;
    drain();
    chk("fair_count", DW'(grant_log.size()), DW'(16));
    for (int i = 0; i < grant_log.size() && i < 16; i++) begin
      chk($sformatf("fair_grant%0d", i), DW'(grant_log[i]), DW'(i % NR));
      cnt[2'(grant_log[i])]++;
    end
    for (int i = 0; i < NR; i++) chk($sformatf("fair_per_req%0d", i), DW'(cnt[i]), DW'(4));

    // Reset mid-WAIT: the in-flight operation must vanish.
    t_op[1] = 3'd1; t_a[1] = rand_wide();
    req_valid = 4'b0010;
    accepted = 1'b0;
    wait_accept("midrst_accept");
    req_valid = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int n = 0; n < 6; n++) step();
    grant_log.delete();
    req_valid = '1;
    accepted = 1'b0;
    wait_accept("midrst_reaccept");
    req_valid = '0;
    chk("midrst_next_grant", DW'(grant_log[0]), DW'(0));
    drain();

`ifdef ALU_ARB_OPCHECK_EN
    t_op[2] = 3'b111; t_a[2] = rand_wide();
    req_valid = 4'b0100;
    accepted = 1'b0;
    wait_accept("illegal_accept");
    req_valid = '0;
    step();
    chk("illegal_resp_error", DW'(resp_error), DW'(1));
    chk("illegal_resp_data", resp_data, '0);
    drain();
`endif

    // Random traffic against the scoreboard.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0) req_valid = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        t_op[i] = 3'($urandom);
        t_a[i]  = rand_wide();
        t_b[i]  = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, DW - 1)) : rand_wide();
      end
      step();
    end
    req_valid = '0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
